// File: rtl/iter_shifter_nbit.sv
// iter_shifter_nbit: multi-cycle SLL/SRL/SRA unit that moves up to STEP bit positions per clock.
// Latency: out_valid rises 1 + ceil(shamt/STEP) edges after the accept edge (the accept edge counts as 1).
// Backpressure: in_ready only in IDLE; the result is held in DONE until out_ready; flush aborts everything.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     request handshake; in_data operand, in_shamt amount, in_mode 00 SLL 01 SRL 10 SRA 11 SLL
//   flush                 synchronous abort; forces IDLE and suppresses any accept or result handshake
//   out_valid/out_ready   result handshake; out_data is the registered result
//   busy                  high while in SHIFT or DONE
module iter_shifter_nbit #(
  parameter int N    = 32,
  parameter int STEP = 1,
  parameter int SW   = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  input  logic [SW-1:0] in_shamt,
  input  logic [1:0]    in_mode,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_data,
  output logic          busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // STEP <= N/2 always fits in the shift-amount width.
  localparam logic [SW-1:0] STEP_W = SW'(STEP);

  state_t        state;
  state_t        state_next;
  logic [N-1:0]  data_q;
  logic [SW-1:0] rem;
  logic [1:0]    mode;

  logic          accept;
  logic [SW-1:0] k;
  logic [SW-1:0] rem_next;
  logic [N-1:0]  shifted;

  assign accept   = in_valid && (state == ST_IDLE) && !flush;

  // Per-cycle shift distance: a full STEP until the final partial step.
  assign k        = (rem < STEP_W) ? rem : STEP_W;
  assign rem_next = rem - k;

  // SRA keeps bit N-1 unchanged on every step, so repeated arithmetic shifts
  // always replicate the original sign bit.
  always_comb begin
    shifted = data_q << k;
    case (mode)
      2'b01:   shifted = data_q >> k;
      2'b10:   shifted = $unsigned($signed(data_q) >>> k);
      default: shifted = data_q << k;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; flush overrides every other transition.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_next = (in_shamt == '0) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (rem_next == '0) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    if (flush) begin
      state_next = ST_IDLE;
    end
  end

  // Outputs decoded from the state register only.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      ST_IDLE:  in_ready  = 1'b1;
      ST_SHIFT: busy      = 1'b1;
      ST_DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: in_ready = 1'b0;
    endcase
  end

  // Datapath: operand, remaining count and mode are only loaded on accept,
  // so input activity outside an accept edge never disturbs them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      rem    <= '0;
      mode   <= '0;
    end else if (accept) begin
      data_q <= in_data;
      rem    <= in_shamt;
      mode   <= in_mode;
    end else if ((state == ST_SHIFT) && !flush) begin
      data_q <= shifted;
      rem    <= rem_next;
    end
  end

  assign out_data = data_q;

endmodule

// File: tb/tb_iter_shifter_nbit.sv
module tb_iter_shifter_nbit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_data;
  logic [4:0]  in_shamt;
  logic [1:0]  in_mode;
  logic        flush;
  logic        out_ready;

  logic        r1, v1, b1;
  logic [31:0] d1;
  logic        r4, v4, b4;
  logic [31:0] d4;

  int n_checks;
  int n_errs;

  // Two instances fed from the same request bus: one stepping by 1, one by 4.
  iter_shifter_nbit #(.N(32), .STEP(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r1),
    .in_data(in_data), .in_shamt(in_shamt), .in_mode(in_mode), .flush(flush),
    .out_valid(v1), .out_ready(out_ready), .out_data(d1), .busy(b1)
  );

  iter_shifter_nbit #(.N(32), .STEP(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r4),
    .in_data(in_data), .in_shamt(in_shamt), .in_mode(in_mode), .flush(flush),
    .out_valid(v4), .out_ready(out_ready), .out_data(d4), .busy(b4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // RISC-V shift semantics applied in one go.
  function automatic logic [31:0] model(input logic [31:0] dat, input logic [4:0] sh, input logic [1:0] md);
    logic signed [31:0] s;
    s = dat;
    case (md)
      2'b01:   return dat >> sh;
      2'b10:   return s >>> sh;
      default: return dat << sh;
    endcase
  endfunction

  function automatic int exp_lat(input int sh, input int step);
    return 1 + (sh + step - 1) / step;
  endfunction

  // Issue one request with out_ready held high; check latency and result of both units.
  task automatic do_req(input logic [31:0] dat, input logic [4:0] sh, input logic [1:0] md);
    logic [31:0] exp;
    logic [31:0] got1, got4;
    int lat1, lat4, e;
    exp = model(dat, sh, md);
    check_eq("rdy1_pre", {31'd0, r1}, 32'd1);
    check_eq("rdy4_pre", {31'd0, r4}, 32'd1);
    in_valid = 1'b1; in_data = dat; in_shamt = sh; in_mode = md;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat1 = 999; lat4 = 999; got1 = '0; got4 = '0; e = 1;
    check_eq("busy1", {31'd0, b1}, 32'd1);
    check_eq("busy4", {31'd0, b4}, 32'd1);
    while ((lat1 == 999 || lat4 == 999) && e <= 80) begin
      if (v1 && lat1 == 999) begin lat1 = e; got1 = d1; end
      if (v4 && lat4 == 999) begin lat4 = e; got4 = d4; end
      // Junk on the request bus while busy must have no effect.
      in_data = $urandom; in_shamt = 5'($urandom); in_mode = 2'($urandom);
      @(posedge clk);
      @(negedge clk);
      e++;
    end
    check_eq("lat1", 32'(lat1), 32'(exp_lat(int'(sh), 1)));
    check_eq("lat4", 32'(lat4), 32'(exp_lat(int'(sh), 4)));
    check_eq("data1", got1, exp);
    check_eq("data4", got4, exp);
    check_eq("rdy1_post", {31'd0, r1}, 32'd1);
    check_eq("rdy4_post", {31'd0, r4}, 32'd1);
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_rdy1"}, {31'd0, r1}, 32'd1);
    check_eq({tag, "_rdy4"}, {31'd0, r4}, 32'd1);
    check_eq({tag, "_vld1"}, {31'd0, v1}, 32'd0);
    check_eq({tag, "_vld4"}, {31'd0, v4}, 32'd0);
    check_eq({tag, "_busy1"}, {31'd0, b1}, 32'd0);
    check_eq({tag, "_busy4"}, {31'd0, b4}, 32'd0);
  endtask

  initial begin
    int seen;
    int e;
    logic [31:0] exp;
    n_checks = 0; n_errs = 0;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_shamt = '0; in_mode = '0;
    flush = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_idle("reset");
    check_eq("reset_d1", d1, 32'd0);
    check_eq("reset_d4", d4, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases
    do_req(32'h0000_0001, 5'd31, 2'b00);
    do_req(32'h8000_00F0, 5'd7, 2'b10);
    do_req(32'h8000_00F0, 5'd7, 2'b01);
    for (int m = 0; m < 4; m++) do_req(32'hDEAD_BEEF, 5'd0, 2'(m));
    do_req(32'h8000_0000, 5'd31, 2'b10);
    do_req(32'hF000_000F, 5'd4, 2'b11);

    // Randomized traffic against the model
    for (int i = 0; i < 40; i++) begin
      do_req($urandom, 5'($urandom), 2'($urandom));
    end

    // Backpressure: result held stable in DONE, new requests refused
    out_ready = 1'b0;
    exp = model(32'h1234_5678, 5'd9, 2'b01);
    in_valid = 1'b1; in_data = 32'h1234_5678; in_shamt = 5'd9; in_mode = 2'b01;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    e = 0;
    while (!(v1 && v4) && e < 60) begin
      @(posedge clk); @(negedge clk); e++;
    end
    check_eq("bp_reach_done", {30'd0, v1, v4}, 32'd3);
    in_valid = 1'b1; in_data = 32'hFFFF_FFFF; in_shamt = 5'd1; in_mode = 2'b00;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); @(negedge clk);
      check_eq("bp_vld", {30'd0, v1, v4}, 32'd3);
      check_eq("bp_rdy", {30'd0, r1, r4}, 32'd0);
      check_eq("bp_d1", d1, exp);
      check_eq("bp_d4", d4, exp);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    check_idle("bp_release");

    // Flush mid-SHIFT: no result may ever appear
    in_valid = 1'b1; in_data = 32'hA5A5_A5A5; in_shamt = 5'd20; in_mode = 2'b00;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); @(negedge clk); end
    flush = 1'b1;
    @(posedge clk); @(negedge clk);
    flush = 1'b0;
    check_idle("flush_shift");
    seen = 0;
    for (int c = 0; c < 30; c++) begin
      if (v1 || v4) seen++;
      @(posedge clk); @(negedge clk);
    end
    check_eq("flush_no_result", 32'(seen), 32'd0);

    // Flush in DONE together with out_ready
    in_valid = 1'b1; in_data = 32'h0BAD_F00D; in_shamt = 5'd0; in_mode = 2'b00;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    check_eq("flush_done_pre", {30'd0, v1, v4}, 32'd3);
    flush = 1'b1;
    @(posedge clk); @(negedge clk);
    flush = 1'b0;
    check_idle("flush_done");

    // Flush coinciding with a request in IDLE: not accepted
    flush = 1'b1; in_valid = 1'b1; in_data = 32'h1; in_shamt = 5'd3; in_mode = 2'b00;
    @(posedge clk); @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    check_idle("flush_idle");

    // Asynchronous reset between edges mid-SHIFT
    in_valid = 1'b1; in_data = 32'h0F0F_0F0F; in_shamt = 5'd20; in_mode = 2'b00;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("arst");
    check_eq("arst_d1", d1, 32'd0);
    check_eq("arst_d4", d4, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_req(32'h0000_0003, 5'd2, 2'b00);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule

// File: doc/iter_shifter_nbit.md
Name: iter_shifter_nbit

Overview:
- Multi-cycle, parametrised shift unit for the RISC-V datapath. Executes SLL, SRL and SRA on an N-bit operand by shifting at most STEP bit positions per clock.
- Replaces single-position combinational shift-by-one instances wherever a variable shift amount is needed.
- Sits beside the ALU. Uses a valid/ready handshake on input and output, so the core can stall on it or an accelerator path can queue work.

Parameters:
- N, 32, operand/result width in bits; must be a power of two, 8 or more.
- STEP, 1, maximum bit positions shifted per cycle; must be a power of two, 1 to N/2.
- SW, $clog2(N), shift-amount width (derived; do not override).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  request present on the in_* bus.
- in_ready  out  1  unit can accept a request this cycle.
- in_data  in  N  operand.
- in_shamt  in  SW  shift amount, 0 to N-1.
- in_mode  in  2  00=SLL, 01=SRL, 10=SRA, 11=reserved (treated as SLL).
- flush  in  1  synchronous abort of any in-flight or unaccepted result.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_data  out  N  shifted result.
- busy  out  1  high in SHIFT or DONE.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, in_ready=1, out_valid=0, out_data=0, busy=0. Internal data, remaining-count and mode registers are cleared. Reset mid-operation discards the work; no result is ever produced for it.
- States: IDLE, SHIFT, DONE.
- in_ready=1 only in IDLE. A request is accepted on an edge where in_valid & in_ready & !flush.
- Accept: latch in_data, mode and rem=in_shamt.
  - If in_shamt==0, go to DONE.
  - Otherwise go to SHIFT.
- SHIFT, each edge:
  - k = min(STEP, rem).
  - Data shifts by k: SLL fills 0s from the LSB; SRL fills 0s from the MSB; SRA replicates the original bit N-1.
  - rem -= k. When the new rem is 0, go to DONE.
- Latency: out_valid rises 1 + ceil(shamt/STEP) edges after the accept edge. Examples: shamt=0 gives 1; N=32, STEP=1, shamt=31 gives 32.
- DONE:
  - out_valid=1 and out_data holds the final value, stable until the handshake.
  - On an edge with out_ready=1, go to IDLE and drop out_valid.
  - No same-cycle back-to-back: a new request is accepted no earlier than the edge after the result is taken (in_ready is low in DONE).
- out_data is registered. Its value outside DONE is don't-care for checking but must not be X after reset.
- flush=1 on any edge forces IDLE and out_valid=0, overriding every other transition, including a simultaneous output handshake and a simultaneous input request (neither is accepted).
- in_data, in_shamt and in_mode changes while not accepted have no effect. Input changes during SHIFT or DONE are ignored.
- Reserved mode 11 behaves exactly as SLL. in_shamt is SW bits, so no out-of-range value exists.
- Arithmetic is bit-exact with the RISC-V SLL/SRL/SRA definitions using shamt[SW-1:0].

Test Plan:
- N=32, STEP=1. Request 0x0000_0001, shamt=31, SLL, out_ready=1 -> out_valid on the 32nd edge after accept, out_data=0x8000_0000, then in_ready returns 1.
- N=32, STEP=4. Request 0x8000_00F0, shamt=7, SRA -> 2 SHIFT cycles (4, then 3); out_valid on edge 3; out_data=0xFF00_0001. The same request with SRL -> 0x0100_0001.
- shamt=0, any mode, data 0xDEAD_BEEF -> out_valid 1 edge after accept, out_data=0xDEAD_BEEF.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid and out_data stay stable, in_ready=0, and a new in_valid is not accepted. Release out_ready -> IDLE.
- flush asserted mid-SHIFT, and separately in DONE together with out_ready=1 -> next state IDLE, out_valid=0, no result delivered. A flush coinciding with in_valid in IDLE is not accepted.
- Assert rst_n=0 asynchronously mid-SHIFT (between edges) -> outputs hit reset values immediately without a clock edge. After release, a fresh SLL of 0x3 by 2 gives 0xC.
